// File: rtl/pipe_mem_sched_pkg.sv
// Shared definitions for the pipeline memory-port scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_mem_sched_pkg;

  // Scheduler states; the encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    SCHED = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    HALT  = 2'd3
  } sched_state_t;

  // Width of the memory wait counter.
  localparam int CNT_W = 4;

  // Default number of memory wait cycles tolerated per access.
  localparam int unsigned MAX_WAIT_DEFAULT = 8;

endpackage

// File: rtl/pipe_mem_sched_wait_counter.sv
// Counts memory wait cycles within one scheduler state and flags a timeout.
// Latency: hit is combinational on the cycle the count would reach limit.
// Backpressure: none; inc is only asserted while memory is stalling.
module wait_counter
  import pipe_mem_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // The stall that would take the count to limit is the one that faults,
  // so limit stalls in a row trip the timeout; a ready in that cycle wins.
  assign hit = inc && (w_cnt_inc == limit);

  // Wait count: cleared on reset or state change, bumped on each stall cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/pipe_mem_sched.sv
// Arbitrates the shared memory port between data access and fetch, then advances the pipeline.
// Latency: one pipeline step is 2 cycles (fetch only) or 3 cycles (data then fetch) plus memory waits.
// Backpressure: mem_ready=0 holds the current access; MAX_WAIT stalls in a row park the FSM in HALT.
module pipe_mem_sched
  import pipe_mem_sched_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic data_we,
  input  logic mem_ready,
  input  logic load_use,
  input  logic branch_taken,
  output logic mem_en,
  output logic mem_sel,
  output logic mem_we,
  output logic pc_load,
  output logic ifid_load,
  output logic idex_load,
  output logic exmem_load,
  output logic memwb_load,
  output logic ifid_flush,
  output logic idex_flush,
  output logic err
);

  localparam logic [CNT_W-1:0] LIMIT = MAX_WAIT[CNT_W-1:0];

  sched_state_t r_state;
  sched_state_t w_next;
  logic         r_err;
  logic         w_wait;
  logic         w_hit;
  logic         w_clr;

  // A stall cycle is any memory-owning state whose access has not completed.
  assign w_wait = ((r_state == DATA) || (r_state == FETCH)) && !mem_ready;
  assign w_clr  = (w_next != r_state);

  wait_counter u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .inc   (w_wait),
    .limit (LIMIT),
    .hit   (w_hit)
  );

  // State register and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= SCHED;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= r_err | (w_next == HALT);
    end
  end

  // Next-state and output decode; everything is held at 0 while in reset.
  always_comb begin
    w_next     = r_state;
    mem_en     = 1'b0;
    mem_sel    = 1'b0;
    mem_we     = 1'b0;
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    idex_load  = 1'b0;
    exmem_load = 1'b0;
    memwb_load = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    err        = rst & r_err;

    case (r_state)
      SCHED: begin
        // Data access goes first so the fetch never overtakes a pending load/store.
        w_next = mem_req ? DATA : FETCH;
      end
      DATA: begin
        mem_en  = rst;
        mem_sel = rst;
        mem_we  = rst & data_we;
        if (mem_ready) begin
          w_next = FETCH;
        end else if (w_hit) begin
          w_next = HALT;
        end
      end
      FETCH: begin
        mem_en = rst;
        if (mem_ready) begin
          w_next = SCHED;
          // Advance cycle: the only cycle in which the pipeline registers move.
          if (branch_taken) begin
            // Redirect squashes both younger instructions, hazard or not.
            pc_load    = rst;
            ifid_load  = rst;
            idex_load  = rst;
            exmem_load = rst;
            memwb_load = rst;
            ifid_flush = rst;
            idex_flush = rst;
          end else if (load_use) begin
            // Hold PC and IF/ID, push a bubble into EX while older stages drain.
            idex_load  = rst;
            exmem_load = rst;
            memwb_load = rst;
            idex_flush = rst;
          end else begin
            pc_load    = rst;
            ifid_load  = rst;
            idex_load  = rst;
            exmem_load = rst;
            memwb_load = rst;
          end
        end else if (w_hit) begin
          w_next = HALT;
        end
      end
      HALT: begin
        w_next = HALT;
      end
      default: begin
        w_next = SCHED;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_mem_sched.sv
// Scoreboard bench for pipe_mem_sched: table-driven cycles, expected outputs queued per cycle.
// Latency: outputs compared mid-cycle (negedge) against the entry pushed when inputs were driven.
// Backpressure: mem_ready stall patterns exercise wait, timeout and recovery.
module tb_pipe_mem_sched;

  logic clk;
  logic rst;
  logic mem_req;
  logic data_we;
  logic mem_ready;
  logic load_use;
  logic branch_taken;
  logic mem_en;
  logic mem_sel;
  logic mem_we;
  logic pc_load;
  logic ifid_load;
  logic idex_load;
  logic exmem_load;
  logic memwb_load;
  logic ifid_flush;
  logic idex_flush;
  logic err;

  int checks;
  int errors;

  logic [10:0] sb[$];

  // Output vector: {mem_en, mem_sel, mem_we, pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, err}
  localparam logic [10:0] O_Z   = 11'b000_00000_00_0;
  localparam logic [10:0] O_F   = 11'b100_00000_00_0;
  localparam logic [10:0] O_ADV = 11'b100_11111_00_0;
  localparam logic [10:0] O_BR  = 11'b100_11111_11_0;
  localparam logic [10:0] O_LU  = 11'b100_00111_01_0;
  localparam logic [10:0] O_DW  = 11'b111_00000_00_0;
  localparam logic [10:0] O_DR  = 11'b110_00000_00_0;
  localparam logic [10:0] O_H   = 11'b000_00000_00_1;

  // Stimulus vector: {rst, mem_req, data_we, mem_ready, load_use, branch_taken}
  localparam logic [5:0] S_RST    = 6'b0_0_0_1_0_0;
  localparam logic [5:0] S_FR     = 6'b1_0_0_1_0_0;
  localparam logic [5:0] S_FW     = 6'b1_0_0_0_0_0;
  localparam logic [5:0] S_ST     = 6'b1_1_1_1_0_0;
  localparam logic [5:0] S_LD     = 6'b1_1_0_1_0_0;
  localparam logic [5:0] S_LDW    = 6'b1_1_0_0_0_0;
  localparam logic [5:0] S_LDWRST = 6'b0_1_0_0_0_0;
  localparam logic [5:0] S_BOTH   = 6'b1_0_0_1_1_1;
  localparam logic [5:0] S_LU     = 6'b1_0_0_1_1_0;
  localparam logic [5:0] S_BR     = 6'b1_0_0_1_0_1;

  pipe_mem_sched #(.MAX_WAIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .data_we      (data_we),
    .mem_ready    (mem_ready),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .mem_en       (mem_en),
    .mem_sel      (mem_sel),
    .mem_we       (mem_we),
    .pc_load      (pc_load),
    .ifid_load    (ifid_load),
    .idex_load    (idex_load),
    .exmem_load   (exmem_load),
    .memwb_load   (memwb_load),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] observed();
    return {mem_en, mem_sel, mem_we, pc_load, ifid_load, idex_load,
            exmem_load, memwb_load, ifid_flush, idex_flush, err};
  endfunction

  // Apply one cycle of stimulus just after the rising edge, return mid-cycle.
  task automatic drive(input logic [5:0] s);
    @(posedge clk);
    #1;
    {rst, mem_req, data_we, mem_ready, load_use, branch_taken} = s;
    @(negedge clk);
  endtask

  task automatic test_reset_fetch();
    logic [5:0]  st[10];
    logic [10:0] ex[10];
    logic [10:0] exp_v;
    logic [10:0] obs;
    st = '{S_RST, S_RST, S_FR, S_FR, S_FR, S_FR, S_FR, S_FR, S_FR, S_FR};
    ex = '{O_Z, O_Z, O_Z, O_ADV, O_Z, O_ADV, O_Z, O_ADV, O_Z, O_ADV};
    for (int i = 0; i < 10; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      obs   = observed();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_fetch row %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_data_store();
    logic [5:0]  st[9];
    logic [10:0] ex[9];
    logic [10:0] exp_v;
    logic [10:0] obs;
    // mem_req drops during the first FETCH and must not change the next step.
    st = '{S_ST, S_ST, S_FR, S_ST, S_ST, S_ST, S_LD, S_LD, S_LD};
    ex = '{O_Z, O_DW, O_ADV, O_Z, O_DW, O_ADV, O_Z, O_DR, O_ADV};
    for (int i = 0; i < 9; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      obs   = observed();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL data_store row %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_hazards();
    logic [5:0]  st[6];
    logic [10:0] ex[6];
    logic [10:0] exp_v;
    logic [10:0] obs;
    st = '{S_BOTH, S_BOTH, S_LU, S_LU, S_BR, S_BR};
    ex = '{O_Z, O_BR, O_Z, O_LU, O_Z, O_BR};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      obs   = observed();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hazards row %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    logic [5:0]  st[21];
    logic [10:0] ex[21];
    logic [10:0] exp_v;
    logic [10:0] obs;
    // 7 stalls then ready on the 8th completes; 8 stalls in a row faults.
    st = '{S_FW, S_FW, S_FW, S_FW, S_FW, S_FW, S_FW, S_FW, S_FR,
           S_FW, S_FW, S_FW, S_FW, S_FW, S_FW, S_FW, S_FW, S_FW,
           S_ST, S_FR, S_LU};
    ex = '{O_Z, O_F, O_F, O_F, O_F, O_F, O_F, O_F, O_ADV,
           O_Z, O_F, O_F, O_F, O_F, O_F, O_F, O_F, O_F,
           O_H, O_H, O_H};
    for (int i = 0; i < 21; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      obs   = observed();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL timeout row %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_halt_reset();
    logic [5:0]  st[5];
    logic [10:0] ex[5];
    logic [10:0] exp_v;
    logic [10:0] obs;
    st = '{S_RST, S_FR, S_FR, S_FR, S_FR};
    ex = '{O_Z, O_Z, O_ADV, O_Z, O_ADV};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      obs   = observed();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL halt_reset row %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_data();
    logic [5:0]  st[14];
    logic [10:0] ex[14];
    logic [10:0] exp_v;
    logic [10:0] obs;
    // Reset lands in the third DATA stall; afterwards a full 7-stall wait must
    // still complete, so the counter cannot have kept the earlier stalls.
    st = '{S_LDW, S_LDW, S_LDW, S_LDWRST,
           S_LDW, S_LDW, S_LDW, S_LDW, S_LDW, S_LDW, S_LDW, S_LDW,
           S_LD, S_FR};
    ex = '{O_Z, O_DR, O_DR, O_Z,
           O_Z, O_DR, O_DR, O_DR, O_DR, O_DR, O_DR, O_DR,
           O_DR, O_ADV};
    for (int i = 0; i < 14; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      obs   = observed();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_data row %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    mem_req      = 1'b0;
    data_we      = 1'b0;
    mem_ready    = 1'b0;
    load_use     = 1'b0;
    branch_taken = 1'b0;
    test_reset_fetch();
    test_data_store();
    test_hazards();
    test_timeout();
    test_halt_reset();
    test_reset_mid_data();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_mem_sched.md
PIPE_MEM_SCHED -- requirements
Module: pipe_mem_sched

Interface
REQ-001 Parameter MAX_WAIT, default 8: memory wait cycles allowed per access before fault.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset (rst=0 sampled at rising edge resets).
REQ-004 mem_req  input  1  EX/MEM stage holds a load/store needing the shared memory port.
REQ-005 data_we  input  1  EX/MEM access is a store.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 load_use  input  1  ID-stage load-use hazard detected.
REQ-008 branch_taken  input  1  EX-stage branch/jump redirect.
REQ-009 mem_en, mem_sel, mem_we  output  1 each  port enable; 0=fetch, 1=data; write strobe.
REQ-010 pc_load, ifid_load, idex_load, exmem_load, memwb_load  output  1 each  pipeline register load enables.
REQ-011 ifid_flush, idex_flush  output  1 each  bubble-insert to IF/ID and ID/EX registers.
REQ-012 err  output  1  sticky memory-timeout fault.

Function
REQ-013 FSM SHALL have states SCHED, DATA, FETCH, HALT.
REQ-014 SCHED: mem_en=0; next DATA if mem_req=1, else FETCH.
REQ-015 DATA: mem_en=1, mem_sel=1, mem_we=data_we; on mem_ready=1 next FETCH, else stay.
REQ-016 FETCH: mem_en=1, mem_sel=0, mem_we=0; on mem_ready=1 next SCHED, else stay.
REQ-017 Advance SHALL be the single cycle with state=FETCH and mem_ready=1; loads are 0 in all other cycles.
REQ-018 On advance with no hazard: all five loads=1, flushes=0.
REQ-019 On advance with load_use=1, branch_taken=0: pc_load=0, ifid_load=0, idex_flush=1, idex/exmem/memwb loads=1.
REQ-020 On advance with branch_taken=1: all loads=1, ifid_flush=1, idex_flush=1; branch_taken overrides load_use.
REQ-021 Flush outputs SHALL be 0 outside the advance cycle.
REQ-022 Data-before-fetch: with mem_req=1, the step is SCHED, DATA, FETCH; without, SCHED, FETCH. Minimum step is 2 cycles (no mem_req) or 3 cycles (mem_req).
REQ-023 mem_req and data_we SHALL be sampled only in SCHED and DATA; changes during FETCH are ignored until the next SCHED.
REQ-024 A 4-bit wait counter SHALL clear on every state change and increment each DATA/FETCH cycle with mem_ready=0.
REQ-025 When the counter reaches MAX_WAIT while mem_ready=0, the next state is HALT and err sets to 1.
REQ-026 mem_ready=1 in the same cycle the counter reaches MAX_WAIT SHALL count as completion, with no fault.
REQ-027 HALT: all outputs 0 except err=1; it exits only via reset.
REQ-028 Outputs SHALL decode combinationally from state, counter and inputs. The only registered state is the FSM state, the counter and err.

Reset
REQ-029 rst=0 at a rising edge: state=SCHED, counter=0, err=0, including mid-access and from HALT.
REQ-030 While rst=0, every output SHALL be forced to 0.
REQ-031 The first cycle after reset release is SCHED.

Structure
REQ-032 The state encoding constants (SCHED=2'd0, DATA=2'd1, FETCH=2'd2, HALT=2'd3) and the MAX_WAIT default SHALL live in the shared processor package.
REQ-033 The wait counter SHALL be one sub-module, wait_counter (inputs clr, inc, limit; output hit).
REQ-034 The FSM and output decode SHALL stay in pipe_mem_sched.

Verification
REQ-035 Test 1: reset, mem_req=0, mem_ready=1 constantly -> advance every 2nd cycle; mem_sel=0 always; err=0.
REQ-036 Test 2: mem_req=1, data_we=1, mem_ready=1 -> sequence SCHED, DATA (mem_we=1, mem_sel=1), FETCH (all loads=1), repeating with period 3.
REQ-037 Test 3: load_use=1 and branch_taken=1 together at advance -> all loads=1, ifid_flush=1, idex_flush=1. Then load_use=1 alone -> pc_load=0, ifid_load=0, idex_flush=1.
REQ-038 Test 4: FETCH with mem_ready=0 for 8 cycles (MAX_WAIT=8) -> HALT, err=1, mem_en=0. A hold of 7 cycles followed by ready=1 on the 8th -> normal advance, err=0.
REQ-039 Test 5: rst=0 asserted during DATA, third wait cycle -> next cycle state=SCHED, outputs 0, counter=0. After release, one SCHED cycle occurs before any mem_en.
REQ-040 Test 6: from HALT, rst=0 for one cycle -> err=0 and normal 2-cycle fetch stepping resumes.
